// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned,
// divide-by-zero short path and flush annulment. Result is {remainder, quotient}.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   dvd_reg;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic               neg_a_reg;
    logic               neg_b_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               ready_reg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic               below;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        abs_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // Full-width shifted remainder so large divisors cannot overflow the trial subtract
        shifted  = {rem_reg, dvd_reg[WIDTH-1]};
        below    = shifted < {1'b0, dvs_reg};
        rem_next = below ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - dvs_reg);
        quot_fix = (neg_a_reg ^ neg_b_reg) ? -dvd_reg : dvd_reg;
        rem_fix  = neg_a_reg ? -rem_reg : rem_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg  <= 1'b0;
                    result_reg <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_reg <= BYZERO;
                        end else begin
                            state_reg <= ON;
                            dvd_reg   <= abs_a;
                            dvs_reg   <= abs_b;
                            rem_reg   <= '0;
                            cnt_reg   <= '0;
                            neg_a_reg <= signed_div_i & opdata1_i[WIDTH-1];
                            neg_b_reg <= signed_div_i & opdata2_i[WIDTH-1];
                        end
                    end
                end
                BYZERO: begin
                    state_reg  <= END;
                    result_reg <= '0;
                    ready_reg  <= 1'b1;
                end
                ON: begin
                    if (annul_i) begin
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        ready_reg  <= 1'b0;
                    end else if (cnt_reg == LAST) begin
                        state_reg  <= END;
                        result_reg <= {rem_fix, quot_fix};
                        ready_reg  <= 1'b1;
                    end else begin
                        rem_reg <= rem_next;
                        dvd_reg <= {dvd_reg[WIDTH-2:0], ~below};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_reg  <= IDLE;
                        ready_reg  <= 1'b0;
                        result_reg <= '0;
                        cnt_reg    <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;
    assign busy_o   = (state_reg == BYZERO) || (state_reg == ON);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: 32-bit and 8-bit instances checked against
// plain-arithmetic division, including latency, flush and async reset.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          ncmp = 0;
    int          nfail = 0;

    logic        sd32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] res32;
    logic        ready32, busy32;

    logic        sd8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        ready8, busy8;

    logic [63:0] exp32_res[$];
    int          exp32_cyc[$];
    logic [15:0] exp8_res[$];
    int          exp8_cyc[$];
    logic        prev32 = 1'b0, prev8 = 1'b0;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(ready32), .busy_o(busy32)
    );

    div_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(ready8), .busy_o(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: language-level truncating division on 64-bit values
    function automatic void model(input int w, input bit sgn, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned q,
                                  output longint unsigned r);
        longint sa, sb;
        longint unsigned mask;
        mask = (64'd1 << w) - 1;
        if (b == 0) begin
            q = 0; r = 0;
        end else if (sgn) begin
            sa = longint'(a); sb = longint'(b);
            if (((a >> (w - 1)) & 1) != 0) sa = sa - (64'sd1 <<< w);
            if (((b >> (w - 1)) & 1) != 0) sb = sb - (64'sd1 <<< w);
            q = longint'(sa / sb) & mask;
            r = longint'(sa % sb) & mask;
        end else begin
            q = (a / b) & mask;
            r = (a % b) & mask;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && ready32 && !prev32) begin
            if (exp32_res.size() == 0) check("w32 unexpected ready", 64'd1, 64'd0);
            else begin
                check("w32 result", res32, exp32_res.pop_front());
                check("w32 latency", 64'(cyc), 64'(exp32_cyc.pop_front()));
            end
        end
        prev32 = ready32;
    end

    always @(negedge clk) begin
        if (!rst && ready8 && !prev8) begin
            if (exp8_res.size() == 0) check("w8 unexpected ready", 64'd1, 64'd0);
            else begin
                check("w8 result", 64'(res8), 64'(exp8_res.pop_front()));
                check("w8 latency", 64'(cyc), 64'(exp8_cyc.pop_front()));
            end
        end
        prev8 = ready8;
    end

    task automatic op32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned q, r;
        bit got;
        model(32, sgn, 64'(a), 64'(b), q, r);
        @(negedge clk);
        sd32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
        exp32_res.push_back({r[31:0], q[31:0]});
        exp32_cyc.push_back(cyc + 1 + ((b == 0) ? 1 : 33));
        $display("w32 op sgn=%0d %h / %h -> q=%h r=%h", sgn, a, b, q[31:0], r[31:0]);
        @(negedge clk);
        check("w32 busy after start", 64'(busy32), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ready32) begin got = 1'b1; break; end
            a32 = $urandom; b32 = $urandom; sd32 = ~sd32;
            @(negedge clk);
        end
        if (!got) check("w32 ready timeout", 64'd0, 64'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("w32 held result", res32, {r[31:0], q[31:0]});
        start32 = 1'b0;
        @(negedge clk);
        check("w32 ready after drop", 64'(ready32), 64'd0);
        check("w32 result after drop", res32, 64'd0);
    endtask

    task automatic op8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        longint unsigned q, r;
        bit got;
        model(8, sgn, 64'(a), 64'(b), q, r);
        @(negedge clk);
        sd8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
        exp8_res.push_back({r[7:0], q[7:0]});
        exp8_cyc.push_back(cyc + 1 + ((b == 0) ? 1 : 9));
        $display("w8 op sgn=%0d %h / %h -> q=%h r=%h", sgn, a, b, q[7:0], r[7:0]);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready8) begin got = 1'b1; break; end
        end
        if (!got) check("w8 ready timeout", 64'd0, 64'd1);
        start8 = 1'b0;
        @(negedge clk);
        check("w8 ready after drop", 64'(ready8), 64'd0);
        check("w8 result after drop", 64'(res8), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset result32", res32, 64'd0);
        check("reset ready32", 64'(ready32), 64'd0);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset result8", 64'(res8), 64'd0);
        rst = 1'b0;

        op32(1'b0, 32'd100, 32'd7);
        op32(1'b1, 32'hFFFFFFF9, 32'd2);
        op32(1'b1, 32'd7, 32'hFFFFFFFE);
        op32(1'b0, 32'd5, 32'd0);
        op32(1'b1, 32'h80000000, 32'hFFFFFFFF);
        op32(1'b0, 32'hFFFFFFFF, 32'd1);
        op32(1'b0, 32'd3, 32'hFFFFFFFF);
        op32(1'b0, 32'hFFFFFFFF, 32'h80000001);

        // Flush in the middle of a long division
        @(negedge clk);
        sd32 = 1'b0; a32 = 32'hFFFFFFFF; b32 = 32'd3; start32 = 1'b1;
        $display("w32 annul op FFFFFFFF / 3");
        repeat (11) @(negedge clk);
        check("w32 busy before annul", 64'(busy32), 64'd1);
        annul32 = 1'b1; start32 = 1'b0;
        @(negedge clk);
        annul32 = 1'b0;
        check("w32 busy after annul", 64'(busy32), 64'd0);
        check("w32 ready after annul", 64'(ready32), 64'd0);
        op32(1'b0, 32'd9, 32'd3);

        // Flush together with a start request in IDLE is ignored
        @(negedge clk);
        b32 = 32'd5; start32 = 1'b1; annul32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; annul32 = 1'b0;
        check("w32 idle annul+start busy", 64'(busy32), 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            op32(1'($urandom_range(0, 1)), a, b);
        end

        op8(1'b0, 8'd200, 8'd3);

        // Async reset mid-division clears outputs before the next edge
        @(negedge clk);
        sd8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        repeat (4) @(negedge clk);
        check("w8 busy before rst", 64'(busy8), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("w8 busy async rst", 64'(busy8), 64'd0);
        check("w8 ready async rst", 64'(ready8), 64'd0);
        check("w8 result async rst", 64'(res8), 64'd0);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        op8(1'b0, 8'd200, 8'd3);
        op8(1'b1, 8'h80, 8'hFF);
        op8(1'b1, 8'hF9, 8'd2);
        for (int i = 0; i < 10; i++)
            op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));

        repeat (3) @(negedge clk);
        check("w32 scoreboard drained", 64'(exp32_res.size()), 64'd0);
        check("w8 scoreboard drained", 64'(exp8_res.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
